// File: rtl/tail_lights_pkg.sv
// ----------------------------------------------------------------------------
// tail_lights_pkg
// Shared constants and helpers for the tail-lights system.
//   - Default turn-signal step, hazard phase and debounce lengths (clk cycles).
//     These values are shared by the input-timing block and the system top.
//   - Channel indices for the three switch inputs.
//   - A counter-width helper that never returns zero.
// ----------------------------------------------------------------------------
package tail_lights_pkg;

    // Default timing constants, in clk cycles.
    localparam int DEFAULT_DIR_PERIOD = 25_000_000;
    localparam int DEFAULT_HAZ_PERIOD = 50_000_000;
    localparam int DEFAULT_DEB_CYCLES = 1_000_000;

    // Switch channel positions inside the packed raw/debounced vectors.
    typedef enum logic [1:0] {
        CH_LEFT  = 2'd0,
        CH_RIGHT = 2'd1,
        CH_HAZ   = 2'd2
    } switch_ch_e;

    localparam int NUM_SWITCHES = 3;

    // Timer channel positions.
    typedef enum logic {
        TMR_DIR = 1'b0,
        TMR_HAZ = 1'b1
    } timer_ch_e;

    localparam int NUM_TIMERS = 2;

    // Debounced switch levels as a bundle, for consumers that prefer a struct.
    typedef struct packed {
        logic haz;
        logic right;
        logic left;
    } switch_levels_t;

    // Bits needed for a counter that must reach n-1.
    // Clamped to at least 1 so that n = 1 or n = 2 still yields a legal vector.
    function automatic int cnt_width(input int n);
        int w;
        if (n <= 2) begin
            w = 1;
        end else begin
            w = $clog2(n);
        end
        return w;
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// ----------------------------------------------------------------------------
// switch_debounce
// One switch channel: 2-flop synchronizer followed by a stable-level counter.
// The output follows the synchronized level only after that level has
// differed from the output for DEB_CYCLES consecutive clk edges.
//
// Ports
//   clk     in   system clock
//   reset   in   asynchronous, active-high reset
//   i_raw   in   asynchronous, bouncing switch level
//   o_level out  synchronized, debounced level (registered)
// ----------------------------------------------------------------------------
module switch_debounce
    import tail_lights_pkg::*;
#(
    parameter int DEB_CYCLES = DEFAULT_DEB_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_level
);

    localparam int CW = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;
    logic          r_level;

    logic          w_differs;
    logic          w_accept;

    // Two-stage synchronizer; nothing downstream looks at i_raw directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_differs = (r_sync2 != r_level);
    assign w_accept  = w_differs && (r_cnt == CNT_LAST);

    // The counter measures how long the synchronized level has disagreed
    // with the output. Any agreement restarts the count, so a glitch shorter
    // than DEB_CYCLES synchronized cycles never reaches the output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_level <= r_sync2;
        end else if (w_differs) begin
            r_cnt   <= r_cnt + 1'b1;
        end else begin
            r_cnt   <= '0;
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/tail_lights_input_timing.sv
// ----------------------------------------------------------------------------
// tail_lights_input_timing
// Input conditioning and timebase for the tail-lights light-control FSM.
//   - Three independent debounce channels (left, right, hazard switches).
//   - Two independent free-running period timers (turn-signal step and
//     hazard phase), each with a synchronous clear from the FSM and a
//     registered one-cycle tick at the end of every period.
//
// Ports
//   clk              in   system clock
//   reset            in   asynchronous, active-high reset
//   left_raw         in   raw left-turn switch
//   right_raw        in   raw right-turn switch
//   haz_raw          in   raw hazard switch
//   clear_timer_dir  in   synchronous clear of the direction timer
//   clear_timer_haz  in   synchronous clear of the hazard timer
//   left             out  debounced left switch level
//   right            out  debounced right switch level
//   haz              out  debounced hazard switch level
//   interr_dir       out  one-cycle tick at end of each direction period
//   interr_haz       out  one-cycle tick at end of each hazard period
// Outputs feed the FSM inputs of the same names directly.
// ----------------------------------------------------------------------------
module tail_lights_input_timing
    import tail_lights_pkg::*;
#(
    parameter int DIR_PERIOD = DEFAULT_DIR_PERIOD,
    parameter int HAZ_PERIOD = DEFAULT_HAZ_PERIOD,
    parameter int DEB_CYCLES = DEFAULT_DEB_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic left_raw,
    input  logic right_raw,
    input  logic haz_raw,
    input  logic clear_timer_dir,
    input  logic clear_timer_haz,
    output logic left,
    output logic right,
    output logic haz,
    output logic interr_dir,
    output logic interr_haz
);

    // ------------------------------------------------------------------
    // Debounce channels
    // ------------------------------------------------------------------
    logic [NUM_SWITCHES-1:0] w_raw;
    logic [NUM_SWITCHES-1:0] w_level;

    assign w_raw[CH_LEFT]  = left_raw;
    assign w_raw[CH_RIGHT] = right_raw;
    assign w_raw[CH_HAZ]   = haz_raw;

    // Channels are fully independent: left and right high together are
    // passed through as-is; resolving that case is the FSM's job.
    for (genvar gi = 0; gi < NUM_SWITCHES; gi++) begin : g_deb
        switch_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_switch_debounce (
            .clk     (clk),
            .reset   (reset),
            .i_raw   (w_raw[gi]),
            .o_level (w_level[gi])
        );
    end

    assign left  = w_level[CH_LEFT];
    assign right = w_level[CH_RIGHT];
    assign haz   = w_level[CH_HAZ];

    // ------------------------------------------------------------------
    // Period timers
    // ------------------------------------------------------------------
    logic [NUM_TIMERS-1:0] w_clear;
    logic [NUM_TIMERS-1:0] w_tick;

    assign w_clear[TMR_DIR] = clear_timer_dir;
    assign w_clear[TMR_HAZ] = clear_timer_haz;

    for (genvar gi = 0; gi < NUM_TIMERS; gi++) begin : g_tmr
        localparam int PERIOD = (gi == int'(TMR_DIR)) ? DIR_PERIOD : HAZ_PERIOD;
        localparam int TW     = cnt_width(PERIOD);
        localparam logic [TW-1:0] TERM = TW'(PERIOD - 1);

        logic [TW-1:0] r_cnt;
        logic          r_tick;

        // Clear has priority over the terminal count, so a clear landing on
        // the last count suppresses that tick. Because the counter restarts
        // at 0 after a tick and PERIOD >= 2, the tick can never be high on
        // two consecutive cycles.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_cnt  <= '0;
                r_tick <= 1'b0;
            end else if (w_clear[gi]) begin
                r_cnt  <= '0;
                r_tick <= 1'b0;
            end else if (r_cnt == TERM) begin
                r_cnt  <= '0;
                r_tick <= 1'b1;
            end else begin
                r_cnt  <= r_cnt + 1'b1;
                r_tick <= 1'b0;
            end
        end

        assign w_tick[gi] = r_tick;
    end

    assign interr_dir = w_tick[TMR_DIR];
    assign interr_haz = w_tick[TMR_HAZ];

endmodule

// File: tb/tb_tail_lights_input_timing.sv
// ----------------------------------------------------------------------------
// tb_tail_lights_input_timing
// Self-checking bench for tail_lights_input_timing with
// DIR_PERIOD=8, HAZ_PERIOD=12, DEB_CYCLES=3.
// ----------------------------------------------------------------------------
module tb_tail_lights_input_timing;

    localparam int DIR_P = 8;
    localparam int HAZ_P = 12;
    localparam int DEB   = 3;

    logic clk = 1'b0;
    logic reset;
    logic left_raw, right_raw, haz_raw;
    logic clear_timer_dir, clear_timer_haz;
    logic left, right, haz, interr_dir, interr_haz;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tail_lights_input_timing #(
        .DIR_PERIOD (DIR_P),
        .HAZ_PERIOD (HAZ_P),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .left_raw        (left_raw),
        .right_raw       (right_raw),
        .haz_raw         (haz_raw),
        .clear_timer_dir (clear_timer_dir),
        .clear_timer_haz (clear_timer_haz),
        .left            (left),
        .right           (right),
        .haz             (haz),
        .interr_dir      (interr_dir),
        .interr_haz      (interr_haz)
    );

    // Record: raw inputs applied before an edge, outputs expected after it.
    typedef struct {
        logic l_raw;
        logic r_raw;
        logic h_raw;
        logic exp_l;
        logic exp_r;
        logic exp_h;
    } vec_t;

    localparam int NVEC = 28;
    vec_t vecs [NVEC];

    task automatic check(input string name, input int idx,
                         input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s[%0d] got=%b expected=%b", name, idx, actual, expected);
        end
    endtask

    // Advance one clock edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic lr, input logic rr, input logic hr,
                                input logic el, input logic er, input logic eh);
        vec_t v;
        v.l_raw = lr; v.r_raw = rr; v.h_raw = hr;
        v.exp_l = el; v.exp_r = er; v.exp_h = eh;
        return v;
    endfunction

    initial begin
        // Debounce table: latency DEB+2 edges, 1- and 2-cycle haz glitches
        // rejected, long haz hold accepted, left and right both high.
        vecs[0]  = mk(0,0,0, 0,0,0);
        vecs[1]  = mk(1,0,0, 0,0,0);   // left_raw rises, first sampling edge
        vecs[2]  = mk(1,0,0, 0,0,0);
        vecs[3]  = mk(1,1,0, 0,0,0);   // right_raw rises
        vecs[4]  = mk(1,1,0, 0,0,0);
        vecs[5]  = mk(1,1,0, 1,0,0);   // left at edge 1+4
        vecs[6]  = mk(1,1,0, 1,0,0);
        vecs[7]  = mk(1,1,0, 1,1,0);   // right at edge 3+4, both high
        vecs[8]  = mk(1,1,1, 1,1,0);   // 1-cycle haz pulse
        vecs[9]  = mk(1,1,0, 1,1,0);
        vecs[10] = mk(1,1,0, 1,1,0);
        vecs[11] = mk(1,1,0, 1,1,0);
        vecs[12] = mk(1,1,1, 1,1,0);   // 2-cycle haz pulse
        vecs[13] = mk(1,1,1, 1,1,0);
        vecs[14] = mk(1,1,0, 1,1,0);
        vecs[15] = mk(1,1,0, 1,1,0);
        vecs[16] = mk(1,1,0, 1,1,0);
        vecs[17] = mk(1,1,0, 1,1,0);
        vecs[18] = mk(1,1,1, 1,1,0);   // haz held
        vecs[19] = mk(1,1,1, 1,1,0);
        vecs[20] = mk(1,1,1, 1,1,0);
        vecs[21] = mk(1,1,1, 1,1,0);
        vecs[22] = mk(1,1,1, 1,1,1);   // haz at edge 18+4
        vecs[23] = mk(0,1,1, 1,1,1);   // left_raw falls
        vecs[24] = mk(0,1,1, 1,1,1);
        vecs[25] = mk(0,1,1, 1,1,1);
        vecs[26] = mk(0,1,1, 1,1,1);
        vecs[27] = mk(0,1,1, 0,1,1);   // left drops at edge 23+4

        // Reset state
        reset = 1'b1;
        left_raw = 1'b0; right_raw = 1'b0; haz_raw = 1'b0;
        clear_timer_dir = 1'b1; clear_timer_haz = 1'b1;
        step();
        step();
        check("rst_left", 0, left, 1'b0);
        check("rst_right", 0, right, 1'b0);
        check("rst_haz", 0, haz, 1'b0);
        check("rst_idir", 0, interr_dir, 1'b0);
        check("rst_ihaz", 0, interr_haz, 1'b0);
        reset = 1'b0;

        // Table-driven debounce vectors, timers held clear.
        for (int i = 0; i < NVEC; i++) begin
            left_raw  = vecs[i].l_raw;
            right_raw = vecs[i].r_raw;
            haz_raw   = vecs[i].h_raw;
            step();
            check("tbl_left", i, left, vecs[i].exp_l);
            check("tbl_right", i, right, vecs[i].exp_r);
            check("tbl_haz", i, haz, vecs[i].exp_h);
            check("tbl_idir", i, interr_dir, 1'b0);
            check("tbl_ihaz", i, interr_haz, 1'b0);
        end

        // Direction timer free-running for 40 cycles from count 0.
        clear_timer_dir = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            step();
            check("dir_run", c, interr_dir, (c % DIR_P) == 0);
            check("dir_run_haz", c, interr_haz, 1'b0);
        end
        clear_timer_dir = 1'b1;
        step();
        check("dir_clr", 0, interr_dir, 1'b0);

        // Hazard clear landing on the terminal count suppresses the tick.
        clear_timer_haz = 1'b0;
        for (int c = 1; c <= HAZ_P - 1; c++) begin
            step();
            check("haz_pre", c, interr_haz, 1'b0);
        end
        clear_timer_haz = 1'b1;             // counter is 11 here
        step();
        check("haz_clr_term", 0, interr_haz, 1'b0);
        clear_timer_haz = 1'b0;
        for (int c = 1; c <= HAZ_P; c++) begin
            step();
            check("haz_post", c, interr_haz, c == HAZ_P);
        end
        clear_timer_haz = 1'b1;
        step();

        // Both timers together; coincident ticks at 24.
        clear_timer_dir = 1'b0;
        clear_timer_haz = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            step();
            check("both_dir", c, interr_dir, (c % DIR_P) == 0);
            check("both_haz", c, interr_haz, (c % HAZ_P) == 0);
        end

        // Reset mid-period with raw inputs held high.
        clear_timer_dir = 1'b1;
        clear_timer_haz = 1'b1;
        left_raw = 1'b1; right_raw = 1'b1; haz_raw = 1'b1;
        for (int c = 0; c < 6; c++) step();
        clear_timer_dir = 1'b0;
        clear_timer_haz = 1'b0;
        for (int c = 0; c < 5; c++) step();  // direction counter now 5
        check("pre_rst_left", 0, left, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("async_left", 0, left, 1'b0);
        check("async_right", 0, right, 1'b0);
        check("async_haz", 0, haz, 1'b0);
        check("async_idir", 0, interr_dir, 1'b0);
        check("async_ihaz", 0, interr_haz, 1'b0);
        step();
        step();
        reset = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            step();
            check("rel_left", c, left, c >= DEB + 2);
            check("rel_right", c, right, c >= DEB + 2);
            check("rel_haz", c, haz, c >= DEB + 2);
            check("rel_idir", c, interr_dir, c == DIR_P);
            check("rel_ihaz", c, interr_haz, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Ticks must never be high on two consecutive sampled cycles.
    logic prev_idir = 1'b0;
    logic prev_ihaz = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            if (prev_idir && interr_dir) begin
                failures++;
                $display("FAIL idir_double got=11 expected=not two in a row");
            end
            if (prev_ihaz && interr_haz) begin
                failures++;
                $display("FAIL ihaz_double got=11 expected=not two in a row");
            end
        end
        prev_idir = interr_dir;
        prev_ihaz = interr_haz;
    end

endmodule

// File: doc/tail_lights_input_timing.md
TAIL_LIGHTS_INPUT_TIMING -- requirements
Module: tail_lights_input_timing

Interface
REQ-001 Parameter DIR_PERIOD, default 25_000_000, is the clk cycles per turn-signal step (>=2).
REQ-002 Parameter HAZ_PERIOD, default 50_000_000, is the clk cycles per hazard on/off phase (>=2).
REQ-003 Parameter DEB_CYCLES, default 1_000_000, is the consecutive stable cycles needed to accept a switch change (>=1).
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 left_raw, right_raw, haz_raw  input  1 each  asynchronous, bouncing switch levels.
REQ-007 clear_timer_dir  input  1  synchronous clear of the direction timer, from the light-control FSM.
REQ-008 clear_timer_haz  input  1  synchronous clear of the hazard timer, from the light-control FSM.
REQ-009 left, right, haz  output  1 each  synchronized, debounced switch levels, registered.
REQ-010 interr_dir  output  1  registered one-cycle tick at the end of each direction period.
REQ-011 interr_haz  output  1  registered one-cycle tick at the end of each hazard period.

Function
REQ-012 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-013 Per input: stable counter increments on each edge where synchronized level != debounced output, and resets to 0 on any edge where they match.
REQ-014 When the counter holds DEB_CYCLES-1 and levels still differ, the debounced output SHALL take the synchronized level and the counter SHALL return to 0 on that edge.
REQ-015 Latency: a clean raw level change SHALL appear on the output at the (DEB_CYCLES+2)th rising edge, counting the first edge that samples the new raw level as edge 1.
REQ-016 A glitch shorter than DEB_CYCLES synchronized cycles SHALL leave the output unchanged.
REQ-017 The three debounce channels are independent; left and right both high SHALL be passed through unmodified.
REQ-018 Direction timer: counter width ceil(log2(DIR_PERIOD)); increments every edge with clear_timer_dir low.
REQ-019 At count DIR_PERIOD-1 with clear low, the next edge SHALL wrap the counter to 0 and set interr_dir for exactly one cycle.
REQ-020 Latency: clear_timer_dir falling with counter 0 SHALL produce interr_dir high in cycle DIR_PERIOD after the first uncleared edge, then every DIR_PERIOD cycles while clear stays low.
REQ-021 clear_timer_dir high SHALL force counter to 0 and interr_dir to 0 on the next edge; clear wins over a simultaneous terminal count (no tick).
REQ-022 The hazard timer SHALL behave identically using HAZ_PERIOD, clear_timer_haz, interr_haz.
REQ-023 The two timers are independent; both may tick in the same cycle.
REQ-024 interr_* SHALL never be high for two consecutive cycles.

Reset
REQ-025 reset high SHALL asynchronously clear synchronizer flops, stable counters, timer counters and all outputs to 0.
REQ-026 Reset mid-period or mid-debounce SHALL discard progress; after release timing restarts from count 0.
REQ-027 Raw inputs held high through reset SHALL reach the outputs DEB_CYCLES+2 edges after release.

Structure
REQ-028 Default period/debounce constants SHALL live in shared package tail_lights_pkg, used by this block and the system top.
REQ-029 One sub-module, switch_debounce (sync + stable counter, parameter DEB_CYCLES), SHALL be instantiated three times; timers are inline.
REQ-030 Outputs connect directly to the light-control FSM inputs of the same names with no glue logic.

Verification (DIR_PERIOD=8, HAZ_PERIOD=12, DEB_CYCLES=3)
REQ-031 left_raw 0->1 clean at edge k -> left=1 from edge k+4; stays 1 while held.
REQ-032 haz_raw 1-cycle and 2-cycle pulses -> haz stays 0; 3-cycle-plus hold -> haz=1.
REQ-033 clear_timer_dir low held 40 cycles from counter 0 -> interr_dir pulses at cycles 8,16,24,32,40, each 1 cycle wide.
REQ-034 clear_timer_haz asserted on the cycle the counter is 11 -> no interr_haz; next tick 12 cycles after clear drops.
REQ-035 Both clears low together -> interr_dir at 8,16,24; interr_haz at 12,24 (coincident at 24).
REQ-036 reset pulsed at counter 5 with left_raw high -> all outputs 0 immediately; left=1 at release+5; interr_dir 8 cycles after release.
